// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path: size encodings and
// the store sequencer state enum.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    function automatic logic size_legal(input logic [1:0] size);
        return size != SIZE_X;
    endfunction

endpackage

// File: rtl/store_split_ctrl_if.sv
// Store request / dmem write bus seen by the store sequencer. The slave
// modport is the controller's view, the master modport the environment's.
interface store_split_ctrl_if #(
    parameter int AWIDTH = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;

    logic              mem_valid;
    logic              mem_ready;
    logic [AWIDTH-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;

    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_we, mem_wdata, busy, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata, busy, err
    );

endinterface

// File: rtl/store_lane_gen.sv
// Combinational lane generator: turns byte offset, size and raw store data
// into an 8-lane write mask and 64-bit lane-positioned data spanning two words.
module store_lane_gen
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [7:0]  lane_mask,
    output logic [63:0] lane_data
);

    logic [3:0]  base_mask;
    logic [31:0] base_data;

    // Illegal size yields an empty mask so nothing can be written by accident.
    always_comb begin
        base_mask = 4'b0000;
        base_data = 32'h0;
        case (size)
            SIZE_B: begin
                base_mask = 4'b0001;
                base_data = {24'h0, data[7:0]};
            end
            SIZE_H: begin
                base_mask = 4'b0011;
                base_data = {16'h0, data[15:0]};
            end
            SIZE_W: begin
                base_mask = 4'b1111;
                base_data = data;
            end
            default: begin
                base_mask = 4'b0000;
                base_data = 32'h0;
            end
        endcase
        lane_mask = {4'b0000, base_mask} << off;
        lane_data = {32'h0, base_data} << {off, 3'b000};
    end

endmodule

// File: rtl/store_split_ctrl.sv
// Store sequencer in front of the dmem write port: issues each store as one
// or two word-aligned beats, splitting stores that straddle a word boundary.
module store_split_ctrl
    import mem_pkg::*;
#(
    parameter int AWIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    store_split_ctrl_if.slave bus
);

    state_t state, next_state;

    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        hi_we_q, hi_we_d;
    logic [31:0]       hi_wdata_q, hi_wdata_d;
    logic              err_q, err_d;

    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic [AWIDTH-1:0] base_addr;

    store_lane_gen u_lane_gen (
        .off       (bus.req_addr[1:0]),
        .size      (bus.req_size),
        .data      (bus.req_data),
        .lane_mask (lane_mask),
        .lane_data (lane_data)
    );

    assign base_addr = {bus.req_addr[AWIDTH-1:2], 2'b00};

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The upper-word beat is captured at accept time so the request inputs
    // are free to change while the split store drains.
    always_comb begin
        next_state = state;
        valid_d    = valid_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        hi_we_d    = hi_we_q;
        hi_wdata_d = hi_wdata_q;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                valid_d = 1'b0;
                addr_d  = '0;
                we_d    = 4'b0000;
                wdata_d = 32'h0;
                if (bus.req_valid) begin
                    if (size_legal(bus.req_size)) begin
                        next_state = BEAT0;
                        valid_d    = 1'b1;
                        addr_d     = base_addr;
                        we_d       = lane_mask[3:0];
                        wdata_d    = lane_data[31:0];
                        hi_we_d    = lane_mask[7:4];
                        hi_wdata_d = lane_data[63:32];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (hi_we_q != 4'b0000) begin
                        next_state = BEAT1;
                        addr_d     = addr_q + AWIDTH'(4);
                        we_d       = hi_we_q;
                        wdata_d    = hi_wdata_q;
                    end else begin
                        next_state = IDLE;
                        valid_d    = 1'b0;
                        addr_d     = '0;
                        we_d       = 4'b0000;
                        wdata_d    = 32'h0;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    next_state = IDLE;
                    valid_d    = 1'b0;
                    addr_d     = '0;
                    we_d       = 4'b0000;
                    wdata_d    = 32'h0;
                end
            end
            default: begin
                next_state = IDLE;
                valid_d    = 1'b0;
                addr_d     = '0;
                we_d       = 4'b0000;
                wdata_d    = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            hi_we_q    <= 4'b0000;
            hi_wdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            hi_we_q    <= hi_we_d;
            hi_wdata_q <= hi_wdata_d;
            err_q      <= err_d;
        end
    end

endmodule
